// File: rtl/led_shift_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : led_shift_gen
// Description : Parametrised LED chaser. A one-hot shift register is stepped
//               by an internal prescaler and moves left, right, bounces
//               between the end LEDs, or holds, as selected by mode.
//
//   Ports
//     clk      in   fabric clock (200 MHz)
//     rst_n    in   synchronous, active-low reset
//     en       in   run enable; low blanks the LEDs and freezes the sequence
//     mode     in   00 left, 01 right, 10 bounce, 11 hold (sampled on tick)
//     div      in   step period minus one, in clk cycles
//     duty     in   8-bit brightness (only with LED_SHIFT_GEN_PWM_EN)
//     data_out out  registered LED drive
//     step     out  one-cycle pulse on each pattern step
//     wrap     out  one-cycle pulse with step when the lit bit wraps/reverses
//
//   Optional macro LED_SHIFT_GEN_PWM_EN adds the duty port and a free-running
//   8-bit PWM counter that gates data_out in the same register stage.
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_shift_gen #(
    parameter int LED_W    = 4,
    parameter int DIV_W    = 28,
    parameter int INIT_POS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
`ifdef LED_SHIFT_GEN_PWM_EN
    input  logic [7:0]       duty,
`endif
    output logic [LED_W-1:0] data_out,
    output logic             step,
    output logic             wrap
);

    localparam logic [1:0] c_MODE_LEFT   = 2'b00;
    localparam logic [1:0] c_MODE_RIGHT  = 2'b01;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b10;
    localparam logic [1:0] c_MODE_HOLD   = 2'b11;

    localparam logic c_DIR_LEFT  = 1'b0;
    localparam logic c_DIR_RIGHT = 1'b1;

    localparam logic [LED_W-1:0] c_POS_INIT = LED_W'(1) << INIT_POS;

    logic [DIV_W-1:0] r_cnt;
    logic [LED_W-1:0] r_pos;
    logic             r_dir;
    logic [LED_W-1:0] r_data;
    logic             r_step;
    logic             r_wrap;

    logic             w_tick;
    logic [LED_W-1:0] w_rot_l;
    logic [LED_W-1:0] w_rot_r;
    logic [LED_W-1:0] w_pos_step;
    logic             w_dir_step;
    logic             w_wrap_step;
    logic [LED_W-1:0] w_pos_next;
    logic [LED_W-1:0] w_gate;

    // Compare with >= so that lowering div below the running count fires on
    // the very next cycle instead of waiting for a counter rollover.
    assign w_tick = en && (r_cnt >= div);

    // Rotations written as shift pairs so LED_W = 1 degenerates cleanly to
    // "pos unchanged" without any out-of-range part selects.
    assign w_rot_l = (r_pos << 1) | (r_pos >> (LED_W - 1));
    assign w_rot_r = (r_pos >> 1) | (r_pos << (LED_W - 1));

    always_comb begin
        w_pos_step  = r_pos;
        w_dir_step  = r_dir;
        w_wrap_step = 1'b0;
        case (mode)
            c_MODE_LEFT: begin
                w_pos_step  = w_rot_l;
                w_dir_step  = c_DIR_LEFT;
                w_wrap_step = r_pos[LED_W-1];
            end
            c_MODE_RIGHT: begin
                w_pos_step  = w_rot_r;
                w_dir_step  = c_DIR_RIGHT;
                w_wrap_step = r_pos[0];
            end
            c_MODE_BOUNCE: begin
                // Direction flips on the tick that lands on an end LED, so the
                // end LED dwells exactly one period. Already sitting on the end
                // while heading into it (possible on entry from left/right
                // mode, or always for LED_W = 1) reverses immediately.
                if (r_dir == c_DIR_LEFT) begin
                    if (r_pos[LED_W-1]) begin
                        w_pos_step  = w_rot_r;
                        w_dir_step  = c_DIR_RIGHT;
                        w_wrap_step = 1'b1;
                    end else begin
                        w_pos_step = w_rot_l;
                        if (w_rot_l[LED_W-1]) begin
                            w_dir_step  = c_DIR_RIGHT;
                            w_wrap_step = 1'b1;
                        end
                    end
                end else begin
                    if (r_pos[0]) begin
                        w_pos_step  = w_rot_l;
                        w_dir_step  = c_DIR_LEFT;
                        w_wrap_step = 1'b1;
                    end else begin
                        w_pos_step = w_rot_r;
                        if (w_rot_r[0]) begin
                            w_dir_step  = c_DIR_LEFT;
                            w_wrap_step = 1'b1;
                        end
                    end
                end
            end
            c_MODE_HOLD: begin
                w_pos_step  = r_pos;
                w_dir_step  = r_dir;
                w_wrap_step = 1'b0;
            end
        endcase
    end

    assign w_pos_next = w_tick ? w_pos_step : r_pos;

`ifdef LED_SHIFT_GEN_PWM_EN
    logic [7:0] r_pwm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm <= 8'd0;
        end else if (en) begin
            r_pwm <= r_pwm + 8'd1;
        end
    end

    assign w_gate = {LED_W{r_pwm < duty}};
`else
    assign w_gate = {LED_W{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_pos  <= c_POS_INIT;
            r_dir  <= c_DIR_LEFT;
            r_data <= '0;
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            if (en) begin
                r_cnt <= w_tick ? '0 : r_cnt + DIV_W'(1);
            end
            if (w_tick) begin
                r_pos <= w_pos_step;
                r_dir <= w_dir_step;
            end
            r_data <= en ? (w_pos_next & w_gate) : '0;
            r_step <= w_tick;
            r_wrap <= w_tick & w_wrap_step;
        end
    end

    assign data_out = r_data;
    assign step     = r_step;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_shift_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_led_shift_gen
// Description : Directed self-checking bench for led_shift_gen (LED_W = 4),
//               with a second LED_W = 1 instance sharing the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_shift_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [27:0] div;
    logic [3:0]  data_out;
    logic        step;
    logic        wrap;
    logic [0:0]  data_out1;
    logic        step1;
    logic        wrap1;
`ifdef LED_SHIFT_GEN_PWM_EN
    logic [7:0]  duty;
`endif

    int checks   = 0;
    int failures = 0;

    led_shift_gen #(.LED_W(4), .DIV_W(28), .INIT_POS(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .div      (div),
`ifdef LED_SHIFT_GEN_PWM_EN
        .duty     (duty),
`endif
        .data_out (data_out),
        .step     (step),
        .wrap     (wrap)
    );

    led_shift_gen #(.LED_W(1), .DIV_W(28), .INIT_POS(0)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .div      (div),
`ifdef LED_SHIFT_GEN_PWM_EN
        .duty     (duty),
`endif
        .data_out (data_out1),
        .step     (step1),
        .wrap     (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_seq [4];
        logic [3:0] prev;
        int         quiet;
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; div = 28'd3;
        repeat (2) cyc();
        checks++;
        if (data_out !== 4'b0000 || step !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got data=%b step=%b wrap=%b expected 0000/0/0", data_out, step, wrap);
        end
        checks++;
        if (data_out1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_w1: got %b expected 0", data_out1);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (data_out !== 4'b0001 || step !== 1'b0) begin
            failures++;
            $display("FAIL first_after_release: got data=%b step=%b expected 0001/0", data_out, step);
        end
        for (int k = 0; k < 4; k++) begin
            prev  = (k == 0) ? 4'b0001 : exp_seq[(k == 0) ? 0 : k - 1];
            quiet = (k == 0) ? 2 : 3;
            for (int q = 0; q < quiet; q++) begin
                cyc();
                checks++;
                if (step !== 1'b0 || data_out !== prev) begin
                    failures++;
                    $display("FAIL left_quiet k=%0d: got data=%b step=%b expected %b/0", k, data_out, step, prev);
                end
            end
            cyc();
            checks++;
            if (step !== 1'b1 || data_out !== exp_seq[k] || wrap !== (k == 3)) begin
                failures++;
                $display("FAIL left_step k=%0d: got data=%b step=%b wrap=%b expected %b/1/%0d",
                         k, data_out, step, wrap, exp_seq[k], (k == 3));
            end
            checks++;
            if (step1 !== 1'b1 || wrap1 !== 1'b1 || data_out1 !== 1'b1) begin
                failures++;
                $display("FAIL w1_left_step k=%0d: got data=%b step=%b wrap=%b expected 1/1/1",
                         k, data_out1, step1, wrap1);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_seq  [7];
        logic       exp_wrap [7];
        exp_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        mode = 2'b10; div = 28'd0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            checks++;
            if (data_out !== exp_seq[k] || step !== 1'b1 || wrap !== exp_wrap[k]) begin
                failures++;
                $display("FAIL bounce k=%0d: got data=%b step=%b wrap=%b expected %b/1/%b",
                         k, data_out, step, wrap, exp_seq[k], exp_wrap[k]);
            end
        end
        checks++;
        if (wrap1 !== 1'b1 || data_out1 !== 1'b1) begin
            failures++;
            $display("FAIL w1_bounce: got data=%b wrap=%b expected 1/1", data_out1, wrap1);
        end
    endtask

    task automatic test_enable_gating();
        mode = 2'b00; div = 28'd9;
        repeat (5) cyc();
        checks++;
        if (data_out !== 4'b0010 || step !== 1'b0) begin
            failures++;
            $display("FAIL gate_pre: got data=%b step=%b expected 0010/0", data_out, step);
        end
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            checks++;
            if (data_out !== 4'b0000 || step !== 1'b0 || wrap !== 1'b0 || data_out1 !== 1'b0) begin
                failures++;
                $display("FAIL gate_low k=%0d: got data=%b step=%b wrap=%b w1=%b expected 0000/0/0/0",
                         k, data_out, step, wrap, data_out1);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (data_out !== 4'b0010 || step !== 1'b0) begin
                failures++;
                $display("FAIL gate_resume k=%0d: got data=%b step=%b expected 0010/0", k, data_out, step);
            end
        end
        cyc();
        checks++;
        if (data_out !== 4'b0100 || step !== 1'b1 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL gate_step: got data=%b step=%b wrap=%b expected 0100/1/0", data_out, step, wrap);
        end
    endtask

    task automatic test_div_shrink_mode();
        logic [3:0] exp_seq  [4];
        logic       exp_wrap [4];
        exp_seq  = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
        div = 28'd100;
        repeat (50) cyc();
        checks++;
        if (step !== 1'b0 || data_out !== 4'b0100) begin
            failures++;
            $display("FAIL shrink_pre: got data=%b step=%b expected 0100/0", data_out, step);
        end
        div = 28'd2;
        cyc();
        checks++;
        if (step !== 1'b1 || data_out !== 4'b1000 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL shrink_step: got data=%b step=%b wrap=%b expected 1000/1/0", data_out, step, wrap);
        end
        mode = 2'b11;
        for (int p = 0; p < 3; p++) begin
            repeat (2) cyc();
            checks++;
            if (step !== 1'b0) begin
                failures++;
                $display("FAIL hold_quiet p=%0d: got step=%b expected 0", p, step);
            end
            cyc();
            checks++;
            if (step !== 1'b1 || data_out !== 4'b1000 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL hold_step p=%0d: got data=%b step=%b wrap=%b expected 1000/1/0",
                         p, data_out, step, wrap);
            end
        end
        mode = 2'b01;
        for (int k = 0; k < 4; k++) begin
            repeat (2) cyc();
            cyc();
            checks++;
            if (step !== 1'b1 || data_out !== exp_seq[k] || wrap !== exp_wrap[k]) begin
                failures++;
                $display("FAIL right_step k=%0d: got data=%b step=%b wrap=%b expected %b/1/%b",
                         k, data_out, step, wrap, exp_seq[k], exp_wrap[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        mode = 2'b10; div = 28'd0;
        cyc();
        checks++;
        if (data_out !== 4'b0100 || step !== 1'b1 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pre: got data=%b step=%b wrap=%b expected 0100/1/0", data_out, step, wrap);
        end
        rst_n = 1'b0; div = 28'd3;
        cyc();
        checks++;
        if (data_out !== 4'b0000 || step !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL midrst_reset: got data=%b step=%b wrap=%b expected 0000/0/0", data_out, step, wrap);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (data_out !== 4'b0001 || step !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release: got data=%b step=%b expected 0001/0", data_out, step);
        end
        repeat (2) cyc();
        cyc();
        checks++;
        if (data_out !== 4'b0010 || step !== 1'b1 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL midrst_left: got data=%b step=%b wrap=%b expected 0010/1/0", data_out, step, wrap);
        end
    endtask

`ifdef LED_SHIFT_GEN_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        rst_n = 1'b0; duty = 8'd64; div = 28'd1000; mode = 2'b11;
        cyc();
        rst_n = 1'b1;
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cyc();
            if (data_out !== 4'b0000) on_cnt++;
        end
        checks++;
        if (on_cnt != 64) begin
            failures++;
            $display("FAIL pwm_duty64: got %0d on-cycles expected 64", on_cnt);
        end
        duty = 8'd0;
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            cyc();
            if (data_out !== 4'b0000) on_cnt++;
        end
        checks++;
        if (on_cnt != 0) begin
            failures++;
            $display("FAIL pwm_duty0: got %0d on-cycles expected 0", on_cnt);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
`ifdef LED_SHIFT_GEN_PWM_EN
        duty = 8'd255;
`endif
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; div = 28'd0;
        test_reset();
        test_bounce();
        test_enable_gating();
        test_div_shrink_mode();
        test_mid_reset();
`ifdef LED_SHIFT_GEN_PWM_EN
        test_pwm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
